ir_key_event_ctrl: RTL and testbench



---
 rtl/ir_key_event_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_ir_key_event_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_key_event_ctrl.sv
`timescale 1ns / 1ps
// NEC frame sequencer: turns decoded IR frames into PRESS/REPEAT/RELEASE events in a FWFT FIFO.
// Optional macro IR_ADDR_FILTER_EN: valid frames whose address differs from ADDR_MATCH are rejected.
module ir_key_event_ctrl #(
    parameter int unsigned CLOCK_FREQ_MHZ  = 12,
    parameter int unsigned HOLD_MS         = 120,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [7:0]  ADDR_MATCH      = 8'h00
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic [31:0] i_Frame,
    input  logic        i_FrameReady,
    output logic        o_EvValid,
    input  logic        i_EvReady,
    output logic [1:0]  o_EvType,
    output logic [7:0]  o_EvAddr,
    output logic [7:0]  o_EvCmd,
    output logic        o_Held,
    output logic [7:0]  o_ErrCount,
    output logic        o_Overflow,
    input  logic        i_ClearStatus
);

    localparam int unsigned PrescReload = CLOCK_FREQ_MHZ * 1000 - 1;
    localparam int unsigned PrescW = (PrescReload > 0) ? $clog2(PrescReload + 1) : 1;
    localparam int unsigned MaxMs0 = (HOLD_MS > REPEAT_DELAY_MS) ? HOLD_MS : REPEAT_DELAY_MS;
    localparam int unsigned MaxMs = (MaxMs0 > REPEAT_RATE_MS) ? MaxMs0 : REPEAT_RATE_MS;
    localparam int unsigned TmrW = $clog2(MaxMs + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] EvPress   = 2'b01;
    localparam logic [1:0] EvRepeat  = 2'b10;
    localparam logic [1:0] EvRelease = 2'b11;

`ifdef IR_ADDR_FILTER_EN
    localparam bit AddrFilter = 1'b1;
`else
    localparam bit AddrFilter = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StHeld, StSwap} state_e;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    logic              rdy_q, rdy_qq, pend_q, rise, pend_take;
    logic [31:0]       pend_frame_q;
    logic [7:0]        addr, naddr, cmd, ncmd;
    logic              frame_ok, same_key, release_due, tick;
    logic [PrescW-1:0] presc_q;
    state_e            state_q;
    logic [TmrW-1:0]   hold_q, rpt_q;
    logic [7:0]        key_addr_q, key_cmd_q;
    logic              push_q;
    logic [1:0]        push_type_q;
    logic [7:0]        push_addr_q, push_cmd_q;
    logic [17:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              full, pop, do_push, drop;

    // Frame edge detection on the registered ready level; a newer frame overwrites a pending one.
    assign rise = rdy_q & ~rdy_qq;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rdy_q        <= 1'b0;
            rdy_qq       <= 1'b0;
            pend_q       <= 1'b0;
            pend_frame_q <= '0;
        end else begin
            rdy_q  <= i_FrameReady;
            rdy_qq <= rdy_q;
            if (rise) begin
                pend_q       <= 1'b1;
                pend_frame_q <= i_Frame;
            end else if (pend_take) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign addr     = rev8(pend_frame_q[31:24]);
    assign naddr    = rev8(pend_frame_q[23:16]);
    assign cmd      = rev8(pend_frame_q[15:8]);
    assign ncmd     = rev8(pend_frame_q[7:0]);
    assign frame_ok = (addr == ~naddr) && (cmd == ~ncmd) && (!AddrFilter || addr == ADDR_MATCH);
    assign same_key = (addr == key_addr_q) && (cmd == key_cmd_q);

    assign tick        = (presc_q == PrescW'(PrescReload));
    assign release_due = (state_q == StHeld) && (hold_q == '0);
    // A timeout RELEASE outranks the pending frame; StSwap defers it one cycle.
    assign pend_take   = pend_q && ((state_q == StIdle) || ((state_q == StHeld) && !release_due));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) presc_q <= '0;
        else            presc_q <= tick ? '0 : presc_q + PrescW'(1);
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            rpt_q       <= '0;
            key_addr_q  <= '0;
            key_cmd_q   <= '0;
            push_q      <= 1'b0;
            push_type_q <= '0;
            push_addr_q <= '0;
            push_cmd_q  <= '0;
        end else begin
            push_q <= 1'b0;
            if ((state_q == StHeld) && tick) begin
                if (hold_q != '0) hold_q <= hold_q - TmrW'(1);
                if (rpt_q != '0)  rpt_q  <= rpt_q - TmrW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (pend_take && frame_ok) begin
                        push_q      <= 1'b1;
                        push_type_q <= EvPress;
                        push_addr_q <= addr;
                        push_cmd_q  <= cmd;
                        key_addr_q  <= addr;
                        key_cmd_q   <= cmd;
                        hold_q      <= TmrW'(HOLD_MS);
                        rpt_q       <= TmrW'(REPEAT_DELAY_MS);
                        state_q     <= StHeld;
                    end
                end
                StHeld: begin
                    if (release_due) begin
                        push_q      <= 1'b1;
                        push_type_q <= EvRelease;
                        push_addr_q <= key_addr_q;
                        push_cmd_q  <= key_cmd_q;
                        state_q     <= StIdle;
                    end else if (pend_take) begin
                        if (frame_ok && same_key) begin
                            hold_q <= TmrW'(HOLD_MS);
                        end else if (frame_ok) begin
                            push_q      <= 1'b1;
                            push_type_q <= EvRelease;
                            push_addr_q <= key_addr_q;
                            push_cmd_q  <= key_cmd_q;
                            key_addr_q  <= addr;
                            key_cmd_q   <= cmd;
                            state_q     <= StSwap;
                        end
                    end else if (rpt_q == '0) begin
                        push_q      <= 1'b1;
                        push_type_q <= EvRepeat;
                        push_addr_q <= key_addr_q;
                        push_cmd_q  <= key_cmd_q;
                        rpt_q       <= TmrW'(REPEAT_RATE_MS);
                    end
                end
                StSwap: begin
                    push_q      <= 1'b1;
                    push_type_q <= EvPress;
                    push_addr_q <= key_addr_q;
                    push_cmd_q  <= key_cmd_q;
                    hold_q      <= TmrW'(HOLD_MS);
                    rpt_q       <= TmrW'(REPEAT_DELAY_MS);
                    state_q     <= StHeld;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_Held = (state_q != StIdle);

    // Event FIFO: first-word fall-through, full-with-pop still accepts the push.
    assign o_EvValid = (count_q != '0);
    assign full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign pop       = o_EvValid && i_EvReady;
    assign do_push   = push_q && (!full || pop);
    assign drop      = push_q && full && !pop;

    always_ff @(posedge i_Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_type_q, push_addr_q, push_cmd_q};
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !pop)      count_q <= count_q + (PtrW + 1)'(1);
            else if (pop && !do_push) count_q <= count_q - (PtrW + 1)'(1);
        end
    end

    assign {o_EvType, o_EvAddr, o_EvCmd} = o_EvValid ? mem_q[rd_ptr_q] : 18'd0;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_ErrCount <= '0;
            o_Overflow <= 1'b0;
        end else if (i_ClearStatus) begin
            o_ErrCount <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (pend_take && !frame_ok && (o_ErrCount != 8'hFF)) o_ErrCount <= o_ErrCount + 8'd1;
            if (drop) o_Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ir_key_event_ctrl.sv
`timescale 1ns / 1ps
// Randomized bench for ir_key_event_ctrl: ms-slot reference model with deadline arithmetic
// and an event scoreboard; frames land mid-millisecond so they never race timer expiry.
module tb_ir_key_event_ctrl;

    localparam int unsigned CycMs = 1000;
    localparam int HOLD  = 6;
    localparam int DELAY = 4;
    localparam int RATE  = 2;
    localparam int DEPTH = 4;
    localparam logic [1:0] EvPress   = 2'b01;
    localparam logic [1:0] EvRepeat  = 2'b10;
    localparam logic [1:0] EvRelease = 2'b11;

    logic        clk, rst_n;
    logic [31:0] i_Frame;
    logic        i_FrameReady, i_EvReady, i_ClearStatus;
    logic        o_EvValid, o_Held, o_Overflow;
    logic [1:0]  o_EvType;
    logic [7:0]  o_EvAddr, o_EvCmd, o_ErrCount;

    ir_key_event_ctrl #(
        .CLOCK_FREQ_MHZ (1),
        .HOLD_MS        (HOLD),
        .REPEAT_DELAY_MS(DELAY),
        .REPEAT_RATE_MS (RATE),
        .FIFO_DEPTH     (DEPTH),
        .ADDR_MATCH     (8'h00)
    ) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_Frame      (i_Frame),
        .i_FrameReady (i_FrameReady),
        .o_EvValid    (o_EvValid),
        .i_EvReady    (i_EvReady),
        .o_EvType     (o_EvType),
        .o_EvAddr     (o_EvAddr),
        .o_EvCmd      (o_EvCmd),
        .o_Held       (o_Held),
        .o_ErrCount   (o_ErrCount),
        .o_Overflow   (o_Overflow),
        .i_ClearStatus(i_ClearStatus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state: deadlines are absolute ms-tick indices.
    logic [17:0] exp_q[$];
    bit          m_held;
    logic [7:0]  m_addr, m_cmd;
    int          m_T, m_hold_dl, m_rpt_dl, m_err;
    bit          m_ovf;
    int          rdy_mode = 2;
    int          ecnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    function automatic logic [7:0] rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] mk_frame(input logic [7:0] a, input logic [7:0] c);
        return {rev(a), rev(~a), rev(c), rev(~c)};
    endfunction

    task automatic m_push(input logic [1:0] t, input logic [7:0] a, input logic [7:0] c);
        if (rdy_mode == 0 && exp_q.size() >= DEPTH) m_ovf = 1'b1;
        else exp_q.push_back({t, a, c});
    endtask

    task automatic m_reset();
        exp_q.delete();
        m_held = 1'b0;
        m_T    = 0;
        m_err  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic m_advance();
        int now;
        now = ecnt / CycMs;
        while (m_T < now) begin
            m_T++;
            if (m_held) begin
                if (m_T == m_hold_dl) begin
                    m_push(EvRelease, m_addr, m_cmd);
                    m_held = 1'b0;
                end else if (m_T == m_rpt_dl) begin
                    m_push(EvRepeat, m_addr, m_cmd);
                    m_rpt_dl = m_T + RATE;
                end
            end
        end
    endtask

    task automatic m_frame(input logic [7:0] a, input logic [7:0] c, input bit good);
        bit ok;
        ok = good;
`ifdef IR_ADDR_FILTER_EN
        if (a != 8'h00) ok = 1'b0;
`endif
        m_advance();
        if (!ok) begin
            if (m_err < 255) m_err++;
        end else if (!m_held) begin
            m_push(EvPress, a, c);
            m_held = 1'b1;
            m_addr = a;
            m_cmd  = c;
            m_hold_dl = m_T + HOLD;
            m_rpt_dl  = m_T + DELAY;
        end else if (a == m_addr && c == m_cmd) begin
            m_hold_dl = m_T + HOLD;
        end else begin
            m_push(EvRelease, m_addr, m_cmd);
            m_addr = a;
            m_cmd  = c;
            m_push(EvPress, a, c);
            m_hold_dl = m_T + HOLD;
            m_rpt_dl  = m_T + DELAY;
        end
    endtask

    // Timed events enter the model as soon as the tick is visible.
    initial forever begin
        @(negedge clk);
        if (rst_n) m_advance();
    end

    initial begin
        i_EvReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_EvReady = 1'b0;
                1:       i_EvReady = ($urandom_range(0, 3) != 0);
                default: i_EvReady = 1'b1;
            endcase
        end
    end

    // Scoreboard and hold-stability monitor.
    logic [17:0] stall_data;
    bit          stall_v = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (o_EvValid && stall_v) check_eq("stable", {o_EvType, o_EvAddr, o_EvCmd}, stall_data);
            stall_v    = o_EvValid && !i_EvReady;
            stall_data = {o_EvType, o_EvAddr, o_EvCmd};
            if (o_EvValid && i_EvReady) begin
                if (exp_q.size() == 0) check_eq("ev_present", 0, 1);
                else check_eq("event", {o_EvType, o_EvAddr, o_EvCmd}, exp_q.pop_front());
            end
        end
    end

    task automatic goto_phase(input int ph);
        int tgt;
        tgt = (ecnt / CycMs + 1) * CycMs + ph;
        while (ecnt < tgt) @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] f, input int hi);
        i_Frame      = f;
        i_FrameReady = 1'b1;
        repeat (hi) @(negedge clk);
        i_FrameReady = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic slot_frame(input logic [7:0] a, input logic [7:0] c, input bit good);
        logic [31:0] f;
        goto_phase($urandom_range(200, 500));
        f = mk_frame(a, c);
        if (!good) f = f ^ (32'd1 << $urandom_range(0, 31));
        m_frame(a, c, good);
        drive(f, 4);
    endtask

    task automatic checkpoint();
        m_advance();
        check_eq("held", o_Held, m_held);
        check_eq("err_count", o_ErrCount, m_err);
        check_eq("overflow", o_Overflow, m_ovf);
    endtask

    task automatic wait_slots(input int n);
        repeat (n) begin
            goto_phase(600);
            checkpoint();
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic clear_status();
        i_ClearStatus = 1'b1;
        @(negedge clk);
        i_ClearStatus = 1'b0;
        m_err = 0;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_Frame = '0;
        i_FrameReady = 1'b0;
        i_ClearStatus = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_valid", o_EvValid, 0);
        check_eq("rst_held", o_Held, 0);
        check_eq("rst_err", o_ErrCount, 0);
        check_eq("rst_ovf", o_Overflow, 0);
        check_eq("rst_data", {o_EvType, o_EvAddr, o_EvCmd}, 0);
        rst_n = 1'b1;

        // Press latency: valid exactly 3 cycles after the sampling edge, then timeout RELEASE.
        goto_phase(300);
        m_frame(8'h00, 8'h45, 1'b1);
        i_Frame      = 32'h00FFA25D;
        i_FrameReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq("latency", o_EvValid, (i == 4));
        end
        i_FrameReady = 1'b0;
        checkpoint();
        wait_slots(HOLD + 2);
        check_eq("release_done", exp_q.size(), 0);

        // Randomized frames, keys and consumer back-pressure.
        rdy_mode = 1;
        for (int s = 0; s < 32; s++) begin
            if ($urandom_range(0, 1) != 0)
                slot_frame($urandom_range(0, 1) ? 8'h12 : 8'h00,
                           $urandom_range(0, 1) ? 8'h46 : 8'h45,
                           $urandom_range(0, 7) != 0);
            else
                goto_phase(600);
            checkpoint();
        end
        wait_slots(HOLD + 2);
        rdy_mode = 2;
        wait_drain();

        // Error counter saturation and clear.
        for (int i = 0; i < 256; i++) begin
            logic [31:0] f;
            f = mk_frame(8'h00, 8'h45) ^ (32'd1 << $urandom_range(0, 31));
            m_frame(8'h00, 8'h45, 1'b0);
            drive(f, 2);
        end
        repeat (4) @(negedge clk);
        check_eq("err_sat", o_ErrCount, 255);
        clear_status();
        check_eq("err_clr", o_ErrCount, 0);

        // Overflow: 5 events into a 4-deep FIFO with the consumer stalled.
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        slot_frame(8'h00, 8'h45, 1'b1);
        slot_frame(8'h00, 8'h46, 1'b1);
        slot_frame(8'h00, 8'h47, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("ovf_set", o_Overflow, 1);
        checkpoint();
        rdy_mode = 2;
        wait_drain();
        wait_slots(HOLD + 3);
        wait_drain();
        clear_status();
        check_eq("ovf_clr", o_Overflow, 0);

        // Asynchronous reset while a key is held and an event is queued.
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        slot_frame(8'h00, 8'h45, 1'b1);
        slot_frame(8'h00, 8'h45, 1'b0);
        goto_phase(700);
        check_eq("pre_rst_valid", o_EvValid, exp_q.size() != 0);
        check_eq("pre_rst_held", o_Held, m_held);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", o_EvValid, 0);
        check_eq("arst_held", o_Held, 0);
        check_eq("arst_err", o_ErrCount, 0);
        check_eq("arst_type", o_EvType, 0);
        @(negedge clk);
        m_reset();
        rdy_mode = 2;
        rst_n = 1'b1;
        wait_slots(HOLD + 3);
        check_eq("no_release", o_EvValid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
